// File: rtl/pc_gen_if.sv
// Request/response signals between the fetch control logic and the PC generator.
// The slave modport is the pc_gen side; the master modport drives its requests.
interface pc_gen_if #(
  parameter int AW        = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic          jtag_reset_i;
  logic          jump_i;
  logic [AW-1:0] jump_addr_i;
  logic [2:0]    hold_i;
  logic          fetch_ready_i;
  logic          inst_c_i;
  logic          push_i;
  logic [AW-1:0] push_addr_i;
  logic          ret_i;
  logic [AW-1:0] pc_o;
  logic          pc_valid_o;
  logic [CW-1:0] ras_cnt_o;
  logic          ret_miss_o;

  modport master (
    output jtag_reset_i, jump_i, jump_addr_i, hold_i, fetch_ready_i, inst_c_i,
           push_i, push_addr_i, ret_i,
    input  pc_o, pc_valid_o, ras_cnt_o, ret_miss_o
  );

  modport slave (
    input  jtag_reset_i, jump_i, jump_addr_i, hold_i, fetch_ready_i, inst_c_i,
           push_i, push_addr_i, ret_i,
    output pc_o, pc_valid_o, ras_cnt_o, ret_miss_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: redirect, return-address-stack prediction, stall and
// sequential increment, with a circular overwrite-oldest return address stack.
module pc_gen #(
  parameter int            AW         = 32,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter int            RAS_DEPTH  = 4,
  parameter bit            C_EXT      = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  pc_gen_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AW-1:0] ALIGN_MASK = C_EXT ? {{(AW-1){1'b1}}, 1'b0}
                                               : {{(AW-2){1'b1}}, 2'b00};
  localparam logic [CW-1:0] CNT_FULL   = CW'(RAS_DEPTH);
  localparam logic [AW-1:0] STEP_C     = AW'(2);
  localparam logic [AW-1:0] STEP_W     = AW'(4);

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic          pc_valid;
  logic          ret_miss;
  logic [CW-1:0] ras_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic [AW-1:0] ras_mem [RAS_DEPTH];

  logic in_reset;
  logic ras_empty;
  logic do_pop;
  logic do_miss;
  logic stall;

  assign in_reset  = rst | bus.jtag_reset_i;
  assign ras_empty = (ras_cnt == '0);
  // wr_ptr points at the next free slot, so the newest entry sits one below it.
  assign top_ptr   = wr_ptr - PW'(1);
  assign do_pop    = ~bus.jump_i & bus.ret_i & ~ras_empty;
  assign do_miss   = ~bus.jump_i & bus.ret_i & ras_empty;
  assign stall     = (bus.hold_i != 3'd0) | ~bus.fetch_ready_i;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    pc_next = pc;
    if (bus.jump_i) begin
      pc_next = bus.jump_addr_i & ALIGN_MASK;
    end else if (do_pop) begin
      pc_next = ras_mem[top_ptr];
    end else if (!stall) begin
      pc_next = pc + ((C_EXT && bus.inst_c_i) ? STEP_C : STEP_W);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      pc       <= RESET_ADDR & ALIGN_MASK;
      pc_valid <= 1'b0;
      ret_miss <= 1'b0;
      ras_cnt  <= '0;
      wr_ptr   <= '0;
    end else begin
      pc       <= pc_next;
      pc_valid <= 1'b1;
      ret_miss <= do_miss;
      if (bus.push_i && !do_pop) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + CW'(1);
      end else if (do_pop && !bus.push_i) begin
        wr_ptr  <= top_ptr;
        ras_cnt <= ras_cnt - CW'(1);
      end
    end
  end

  // NOTE: the stack storage has no reset; ras_cnt alone decides which entries
  // are meaningful, so the array can map onto plain RAM/registers without reset.
  always_ff @(posedge clk) begin
    if (!in_reset && bus.push_i) begin
      // Push with a pop replaces the top entry; otherwise write the free slot,
      // which is the oldest entry once the stack is full.
      ras_mem[do_pop ? top_ptr : wr_ptr] <= bus.push_addr_i;
    end
  end

  assign bus.pc_o       = pc;
  assign bus.pc_valid_o = pc_valid;
  assign bus.ras_cnt_o  = ras_cnt;
  assign bus.ret_miss_o = ret_miss;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a default-parameter instance (C_EXT=1, 4-deep RAS)
// and a narrow instance (AW=16, C_EXT=0, 2-deep RAS, odd RESET_ADDR).
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.AW(32), .RAS_DEPTH(4)) a ();
  pc_gen_if #(.AW(16), .RAS_DEPTH(2)) b ();

  pc_gen #(.AW(32), .RESET_ADDR(32'h0), .RAS_DEPTH(4), .C_EXT(1'b1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a)
  );

  pc_gen #(.AW(16), .RESET_ADDR(16'h1003), .RAS_DEPTH(2), .C_EXT(1'b0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b)
  );

  typedef struct packed {
    logic        rst;
    logic        jtag;
    logic        jump;
    logic [31:0] jaddr;
    logic [2:0]  hold;
    logic        ready;
    logic        c;
    logic        push;
    logic [31:0] paddr;
    logic        ret;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [2:0]  exp_cnt;
    logic        exp_miss;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  function automatic vec_t mk(bit r, bit jp, logic [31:0] ja, logic [2:0] h, bit rd,
                              bit c, bit p, logic [31:0] pa, bit rt,
                              logic [31:0] pc, bit v, logic [2:0] n, bit m);
    vec_t t;
    t.rst = r;  t.jtag = 1'b0; t.jump = jp; t.jaddr = ja; t.hold = h;
    t.ready = rd; t.c = c; t.push = p; t.paddr = pa; t.ret = rt;
    t.exp_pc = pc; t.exp_valid = v; t.exp_cnt = n; t.exp_miss = m;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(vec_t t);
    rst_a            = t.rst;
    a.jtag_reset_i   = t.jtag;
    a.jump_i         = t.jump;
    a.jump_addr_i    = t.jaddr;
    a.hold_i         = t.hold;
    a.fetch_ready_i  = t.ready;
    a.inst_c_i       = t.c;
    a.push_i         = t.push;
    a.push_addr_i    = t.paddr;
    a.ret_i          = t.ret;
  endtask

  task automatic drive_b(vec_t t);
    rst_b            = t.rst;
    b.jtag_reset_i   = t.jtag;
    b.jump_i         = t.jump;
    b.jump_addr_i    = t.jaddr[15:0];
    b.hold_i         = t.hold;
    b.fetch_ready_i  = t.ready;
    b.inst_c_i       = t.c;
    b.push_i         = t.push;
    b.push_addr_i    = t.paddr[15:0];
    b.ret_i          = t.ret;
  endtask

  // Drive at the falling edge, sample 1 ns after the following rising edge.
  task automatic apply_a(string tag, vec_t t);
    drive_a(t);
    @(posedge clk); #1;
    check({tag, " pc"},    a.pc_o,                t.exp_pc);
    check({tag, " valid"}, 32'(a.pc_valid_o),     32'(t.exp_valid));
    check({tag, " cnt"},   32'(a.ras_cnt_o),      32'(t.exp_cnt));
    check({tag, " miss"},  32'(a.ret_miss_o),     32'(t.exp_miss));
    @(negedge clk);
  endtask

  task automatic apply_b(string tag, vec_t t);
    drive_b(t);
    @(posedge clk); #1;
    check({tag, " pc"},    32'(b.pc_o),           t.exp_pc);
    check({tag, " valid"}, 32'(b.pc_valid_o),     32'(t.exp_valid));
    check({tag, " cnt"},   32'(b.ras_cnt_o),      32'(t.exp_cnt));
    check({tag, " miss"},  32'(b.ret_miss_o),     32'(t.exp_miss));
    @(negedge clk);
  endtask

  initial begin
    vec_t t;

    //            r jp jaddr          h  rd c p paddr   rt   pc            v cnt m
    tbl_a.push_back(mk(1, 0, 32'h0,        0, 1, 0, 0, 32'h0,  0,  32'h0,        0, 0, 0));
    tbl_a.push_back(mk(1, 1, 32'h40,       1, 1, 0, 1, 32'h99, 1,  32'h0,        0, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  0,  32'h4,        1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 1, 0, 32'h0,  0,  32'h6,        1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  0,  32'hA,        1, 0, 0));
    tbl_a.push_back(mk(0, 1, 32'h100,      0, 1, 0, 0, 32'h0,  0,  32'h100,      1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  0,  32'h100,      1, 0, 0));
    tbl_a.push_back(mk(0, 1, 32'h203,      1, 1, 0, 0, 32'h0,  0,  32'h202,      1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  0,  32'h202,      1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  0,  32'h206,      1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,  0,  32'h206,      1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        7, 1, 0, 0, 32'h0,  0,  32'h206,      1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        4, 0, 1, 0, 32'h0,  0,  32'h206,      1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 1, 0, 1, 32'h10, 0,  32'h206,      1, 1, 0));
    tbl_a.push_back(mk(0, 1, 32'h300,      0, 1, 0, 1, 32'h20, 0,  32'h300,      1, 2, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 0, 0, 1, 32'h30, 0,  32'h300,      1, 3, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 1, 1, 32'h40, 0,  32'h302,      1, 4, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h50, 0,  32'h306,      1, 4, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h50,       1, 3, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  1,  32'h40,       1, 2, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,  1,  32'h30,       1, 1, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h20,       1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h24,       1, 0, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  0,  32'h28,       1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  1,  32'h28,       1, 0, 1));
    tbl_a.push_back(mk(0, 1, 32'h400,      0, 1, 0, 0, 32'h0,  1,  32'h400,      1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h60, 0,  32'h404,      1, 1, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h80, 0,  32'h408,      1, 2, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h90, 1,  32'h80,       1, 2, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h90,       1, 1, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h60,       1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'hA0, 0,  32'h64,       1, 1, 0));
    tbl_a.push_back(mk(0, 1, 32'h500,      0, 1, 0, 0, 32'h0,  1,  32'h500,      1, 1, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'hA0,       1, 0, 0));
    tbl_a.push_back(mk(0, 1, 32'hFFFFFFFD, 0, 1, 0, 0, 32'h0,  0,  32'hFFFFFFFC, 1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  0,  32'h0,        1, 0, 0));
    tbl_a.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h0,  0,  32'hFFFFFFFE, 1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 1, 0, 32'h0,  0,  32'h0,        1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h11, 0,  32'h4,        1, 1, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h22, 0,  32'h8,        1, 2, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h33, 0,  32'hC,        1, 3, 0));
    tbl_a.push_back(mk(1, 1, 32'h700,      1, 1, 0, 1, 32'h44, 1,  32'h0,        0, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  0,  32'h4,        1, 0, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h8,        1, 0, 1));

    // Narrow instance: word step only, 2-bit alignment, reset address 0x1003 -> 0x1000.
    tbl_b.push_back(mk(1, 0, 32'h0,        0, 1, 0, 0, 32'h0,  0,  32'h1000,     0, 0, 0));
    tbl_b.push_back(mk(0, 0, 32'h0,        0, 1, 1, 0, 32'h0,  0,  32'h1004,     1, 0, 0));
    tbl_b.push_back(mk(0, 1, 32'h2207,     0, 1, 0, 0, 32'h0,  0,  32'h2204,     1, 0, 0));
    tbl_b.push_back(mk(0, 1, 32'hFFFF,     0, 1, 0, 0, 32'h0,  0,  32'hFFFC,     1, 0, 0));
    tbl_b.push_back(mk(0, 0, 32'h0,        0, 1, 1, 0, 32'h0,  0,  32'h0,        1, 0, 0));
    tbl_b.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h40, 0,  32'h4,        1, 1, 0));
    tbl_b.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h50, 0,  32'h8,        1, 2, 0));
    tbl_b.push_back(mk(0, 0, 32'h0,        0, 1, 0, 1, 32'h60, 0,  32'hC,        1, 2, 0));
    tbl_b.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h60,       1, 1, 0));
    tbl_b.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h50,       1, 0, 0));
    tbl_b.push_back(mk(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,  1,  32'h54,       1, 0, 1));

    drive_a(tbl_a[0]);
    drive_b(tbl_b[0]);
    @(negedge clk);

    for (int i = 0; i < tbl_a.size(); i++) apply_a($sformatf("a[%0d]", i), tbl_a[i]);

    // Debug reset mid-operation, then confirm the stack pointers restarted cleanly.
    t = mk(0, 0, 32'h0, 0, 1, 0, 1, 32'hB0, 0, 32'h0C, 1, 1, 0);
    apply_a("jt push0", t);
    t = mk(0, 0, 32'h0, 0, 1, 0, 1, 32'hC0, 0, 32'h10, 1, 2, 0);
    apply_a("jt push1", t);
    t = mk(0, 1, 32'h800, 0, 1, 0, 1, 32'hEE, 1, 32'h0, 0, 0, 0);
    t.jtag = 1'b1;
    apply_a("jt reset", t);
    t = mk(0, 0, 32'h0, 0, 1, 0, 1, 32'hD0, 0, 32'h4, 1, 1, 0);
    apply_a("jt push2", t);
    t = mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 32'hD0, 1, 0, 0);
    apply_a("jt ret0", t);
    t = mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 32'hD4, 1, 0, 1);
    apply_a("jt ret1", t);
    t = mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 32'hD8, 1, 0, 0);
    apply_a("jt idle", t);

    for (int i = 0; i < tbl_b.size(); i++) apply_b($sformatf("b[%0d]", i), tbl_b[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter AW, 32, PC and address width in bits, minimum 8.
REQ-002 Parameter RESET_ADDR, 0, PC value loaded on reset; bit 0 (bits 1:0 when C_EXT=0) forced to 0.
REQ-003 Parameter RAS_DEPTH, 4, return-address-stack entries, power of two, 2..16.
REQ-004 Parameter C_EXT, 1, 1 selects 2-byte alignment and a 2/4-byte step; 0 selects a fixed 4-byte step.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 jtag_reset_i  in  1  debug reset, same effect as rst.
REQ-008 jump_i  in  1  redirect request.
REQ-009 jump_addr_i  in  AW  redirect target.
REQ-010 hold_i  in  3  pipeline hold level; a value of 1 or more freezes the PC.
REQ-011 fetch_ready_i  in  1  fetch side accepts pc_o this cycle.
REQ-012 inst_c_i  in  1  instruction at pc_o is 16-bit; ignored when C_EXT=0.
REQ-013 push_i  in  1  call detected; push push_addr_i onto the RAS.
REQ-014 push_addr_i  in  AW  return address to push.
REQ-015 ret_i  in  1  return detected; predict from the RAS.
REQ-016 pc_o  out  AW  current fetch address.
REQ-017 pc_valid_o  out  1  pc_o is valid for fetch.
REQ-018 ras_cnt_o  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
REQ-019 ret_miss_o  out  1  one-cycle pulse: ret_i accepted while the RAS was empty.

Function
REQ-020 The next PC is chosen by fixed priority: reset, then jump, then RAS return, then hold/stall, then increment.
REQ-021 Redirect: jump_i=1 loads pc_o <= jump_addr_i with the alignment bits masked to 0; this ignores hold_i and fetch_ready_i.
REQ-022 Return: jump_i=0, ret_i=1 and RAS non-empty loads pc_o <= RAS top and pops one entry; this ignores hold_i.
REQ-023 Return miss: jump_i=0, ret_i=1 and RAS empty pulses ret_miss_o for one cycle; the PC then follows the hold/increment rules.
REQ-024 jump_i=1 together with ret_i=1: the jump wins; no pop occurs and ret_miss_o is not asserted.
REQ-025 Stall: hold_i>=1 or fetch_ready_i=0 keeps pc_o unchanged.
REQ-026 Increment: pc_o <= pc_o + 2 when C_EXT=1 and inst_c_i=1; otherwise pc_o <= pc_o + 4.
REQ-027 Wrap-around: all PC arithmetic is modulo 2^AW; the maximum aligned address plus step wraps to a small value with no flag.
REQ-028 The RAS is circular: the push pointer advances on push and retreats on pop; ras_cnt_o saturates at RAS_DEPTH.
REQ-029 Push while full overwrites the oldest entry, and ras_cnt_o stays at RAS_DEPTH.
REQ-030 push_i is honoured regardless of jump_i, hold_i and fetch_ready_i.
REQ-031 Push with an accepted pop in the same cycle: the top entry is replaced by push_addr_i and ras_cnt_o is unchanged.
REQ-032 pc_valid_o is 0 during reset and becomes 1 on the first clock edge where rst=0 and jtag_reset_i=0.
REQ-033 pc_valid_o then stays 1 until the next reset.
REQ-034 All outputs are registered; the latency from any input to pc_o is exactly one clock.

Reset
REQ-035 While rst or jtag_reset_i is 1, the block sets pc_o=RESET_ADDR, pc_valid_o=0, ras_cnt_o=0 and ret_miss_o=0, and resets the RAS pointers.
REQ-036 RAS entry contents are don't-care after reset.
REQ-037 Reset overrides jump, ret, push and hold in the same cycle, including in mid-operation.

Verification
REQ-038 Release reset with RESET_ADDR=0, C_EXT=1, fetch_ready_i=1 and inst_c_i pattern 0,1,0 -> pc_o = 0, 4, 6, 0xA, and pc_valid_o rises after the first edge.
REQ-039 pc_o=0x100, hold_i=1 for 3 cycles, with jump_i=1 to 0x203 in the second cycle -> pc_o = 0x100 then 0x202, held for one more cycle, then 0x206.
REQ-040 With RAS_DEPTH=4, push 0x10, 0x20, 0x30, 0x40, 0x50, then ret_i five times -> pc_o = 0x50, 0x40, 0x30, 0x20, then a ret_miss_o pulse on the fifth return.
REQ-041 With RAS top 0x80, push_i=1 with 0x90 and ret_i=1 in the same cycle -> pc_o=0x80 and ras_cnt_o unchanged; the next ret -> pc_o=0x90.
REQ-042 With AW=32 and pc_o=0xFFFFFFFC, increment by 4 -> pc_o=0x00000000.
REQ-043 Assert rst during a jump with ras_cnt_o=3 -> pc_o=RESET_ADDR, ras_cnt_o=0 and pc_valid_o=0 on the next edge.
